// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    // Occupancy needs one bit more than the pointers so that DEPTH itself is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [$clog2(DEPTH)-1:0] read_addr,
    output logic [DATA_WIDTH-1:0]    read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy flags, error pulses, flush, and registered-read or
// first-word-fall-through output.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          write_en,
    input  logic [DATA_WIDTH-1:0]         write_data,
    input  logic                          read_en,
    output logic [DATA_WIDTH-1:0]         read_data,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr_ok;
    logic                  rd_ok;

    // Handshake: write_en acts as valid with !full as ready, read_en as ready with !empty
    // as valid; an operation is accepted only when both sides agree and no flush is pending.
    assign wr_ok = write_en && !full && !flush;
    assign rd_ok = read_en && !empty && !flush;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk       (clk),
        .write_en  (wr_ok),
        .write_addr(wr_ptr),
        .write_data(write_data),
        .read_addr (rd_ptr),
        .read_data (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            data_q    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            data_q    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - CW'(1);
            end
            if (FWFT == 0 && rd_ok) data_q <= head;
            overflow  <= write_en && full;
            underflow <= read_en && empty;
        end
    end

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

    // In fall-through mode the head word is shown directly; zero while empty keeps the
    // output clean after reset and flush.
    assign read_data = (FWFT != 0) ? (empty ? '0 : head) : data_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: a registered-read and a fall-through FIFO driven by the same stimulus.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          read_en;

    logic [DW-1:0] rd0, rd1;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic          full1, empty1, af1, ae1, ovf1, unf1;
    logic [CW-1:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status of both instances must agree; they share every input.
    task automatic chk_stat(input string tag, input int c, input logic f, input logic e,
                            input logic af, input logic ae);
        chk({tag, ".count0"}, 32'(cnt0), 32'(c));
        chk({tag, ".flags0"}, {28'd0, full0, empty0, af0, ae0}, {28'd0, f, e, af, ae});
        chk({tag, ".count1"}, 32'(cnt1), 32'(c));
        chk({tag, ".flags1"}, {28'd0, full1, empty1, af1, ae1}, {28'd0, f, e, af, ae});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re, input logic fl);
        write_en   = we;
        write_data = wd;
        read_en    = re;
        flush      = fl;
    endtask

    initial begin
        logic [DW-1:0] fill_v [4];
        fill_v = '{8'h00, 8'h44, 8'h88, 8'hCC};

        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        chk_stat("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset.rd0", 32'(rd0), 32'h0);
        chk("reset.err", {30'd0, ovf0, unf0}, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Fill and threshold crossings.
        drive(1'b1, fill_v[0], 1'b0, 1'b0); tick();
        chk_stat("w1", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("w1.head1", 32'(rd1), 32'h00);
        drive(1'b1, fill_v[1], 1'b0, 1'b0); tick();
        chk_stat("w2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, fill_v[2], 1'b0, 1'b0); tick();
        chk_stat("w3", 3, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, fill_v[3], 1'b0, 1'b0); tick();
        chk_stat("w4", 4, 1'b1, 1'b0, 1'b1, 1'b0);

        // Overflow: 55 dropped.
        drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
        chk("ovf.pulse", {30'd0, ovf0, ovf1}, 32'h3);
        chk_stat("ovf", 4, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk("ovf.clear", {30'd0, ovf0, ovf1}, 32'h0);

        // Drain in order; fall-through head leads the registered output by one read.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d.head1", i), 32'(rd1), 32'(fill_v[i]));
            drive(1'b0, '0, 1'b1, 1'b0); tick();
            chk($sformatf("drain%0d.rd0", i), 32'(rd0), 32'(fill_v[i]));
            chk($sformatf("drain%0d.count", i), 32'(cnt0), 32'(3 - i));
        end
        chk_stat("drained", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk("hold.rd0", 32'(rd0), 32'hCC);

        // Underflow.
        drive(1'b0, '0, 1'b1, 1'b0); tick();
        chk("unf.pulse", {30'd0, unf0, unf1}, 32'h3);
        chk_stat("unf", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("unf.rd0", 32'(rd0), 32'hCC);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk("unf.clear", {30'd0, unf0, unf1}, 32'h0);

        // Write + read while empty: write accepted, read rejected.
        drive(1'b1, 8'h11, 1'b1, 1'b0); tick();
        chk("wre.unf", {30'd0, unf0, unf1}, 32'h3);
        chk_stat("wre", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wre.head1", 32'(rd1), 32'h11);
        chk("wre.rd0", 32'(rd0), 32'hCC);

        // Six write/read pairs across the pointer wrap; occupancy stays at 1.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0); tick();
            chk($sformatf("pair%0d.rd0", i), 32'(rd0), (i == 0) ? 32'h11 : 32'(8'hA0 + 8'(i - 1)));
            chk($sformatf("pair%0d.head1", i), 32'(rd1), 32'(8'hA0 + 8'(i)));
            chk($sformatf("pair%0d.count", i), 32'(cnt1), 32'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0); tick();
        chk("pair.last.rd0", 32'(rd0), 32'hA5);
        chk_stat("pair.end", 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Read + write while full: read accepted, write rejected.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0); tick();
        end
        chk_stat("refill", 4, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0); tick();
        chk("rwf.ovf", {30'd0, ovf0, ovf1}, 32'h3);
        chk_stat("rwf", 3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rwf.rd0", 32'(rd0), 32'hB0);
        chk("rwf.head1", 32'(rd1), 32'hB1);

        // Flush with three words stored, overriding write and read requests.
        drive(1'b1, 8'h77, 1'b1, 1'b1); tick();
        chk_stat("flush", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush.rd0", 32'(rd0), 32'h0);
        chk("flush.err", {28'd0, ovf0, unf0, ovf1, unf1}, 32'h0);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk("flush.after.err", {28'd0, ovf0, unf0, ovf1, unf1}, 32'h0);

        // Asynchronous reset in the middle of a write.
        drive(1'b1, 8'hC1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b0); tick();
        chk_stat("pre_rst", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hC3, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk_stat("async_rst", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("async_rst.rd0", 32'(rd0), 32'h0);
        tick();
        chk_stat("rst_held", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        drive(1'b1, 8'hD7, 1'b0, 1'b0); tick();
        chk_stat("post_rst", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst.head1", 32'(rd1), 32'hD7);
        drive(1'b0, '0, 1'b1, 1'b0); tick();
        chk("post_rst.rd0", 32'(rd0), 32'hD7);
        chk_stat("post_rst.drain", 0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
